// File: rtl/tl_mem_slave.sv
// Single-beat memory responder on the A/D link: serves Get/PutFullData from a word memory,
// one request at a time, with a response delay that software can program per request.
module tl_mem_slave #(
  parameter int A_W          = 55,
  parameter int D_W          = 40,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BASE_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [A_W-1:0] a_channel,
  output logic           a_ready,
  output logic [D_W-1:0] d_channel,
  input  logic [2:0]     extra_wait,
  output logic [7:0]     drop_count
);

  localparam int A_DATA_LO  = 2;
  localparam int A_ADDR_LO  = A_DATA_LO + DATA_W;
  localparam int A_SRC_LO   = A_ADDR_LO + ADDR_W;
  localparam int A_SIZE_LO  = A_SRC_LO + 2;
  localparam int A_PARAM_LO = A_SIZE_LO + 3;
  localparam int A_OP_LO    = A_PARAM_LO + 3;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              r_state;
  logic [15:0]         r_cnt;
  logic [2:0]          r_op;
  logic [2:0]          r_size;
  logic [1:0]          r_src;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_a_ready;
  logic                r_d_valid;
  logic                r_d_error;
  logic [2:0]          r_d_opcode;
  logic [DATA_W-1:0]   r_d_data;
  logic [1:0]          r_d_source;
  logic [7:0]          r_drop;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic                w_a_valid;
  logic [15:0]         w_wait;
  logic                w_get;
  logic                w_put;
  logic                w_unused;

  assign w_a_valid = a_channel[1];
  assign w_wait    = 16'(BASE_LATENCY - 1) + {13'd0, extra_wait};
  assign w_get     = (r_op == 3'd4) && (r_size == 3'd5);
  assign w_put     = (r_op == 3'd0) && (r_size == 3'd5);
  assign w_unused  = ^{a_channel[A_PARAM_LO +: 3], a_channel[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_op       <= '0;
      r_size     <= '0;
      r_src      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_a_ready  <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_error  <= 1'b0;
      r_d_opcode <= '0;
      r_d_data   <= '0;
      r_d_source <= '0;
      r_drop     <= '0;
    end else begin
      r_d_valid <= 1'b0;
      // Requests arriving while busy are lost; the master is expected to retry them.
      if (w_a_valid && (r_state != StIdle) && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
      case (r_state)
        StIdle: begin
          r_a_ready <= 1'b1;
          if (w_a_valid) begin
            r_op    <= a_channel[A_OP_LO +: 3];
            r_size  <= a_channel[A_SIZE_LO +: 3];
            r_src   <= a_channel[A_SRC_LO +: 2];
            r_addr  <= a_channel[A_ADDR_LO +: ADDR_W];
            r_wdata <= a_channel[A_DATA_LO +: DATA_W];
            r_cnt   <= w_wait;
            if (w_wait == 16'd0) begin
              r_state <= StResp;
            end else begin
              r_state   <= StWait;
              r_a_ready <= 1'b0;
            end
          end
        end
        StWait: begin
          if (r_cnt == 16'd1) begin
            r_cnt     <= '0;
            r_state   <= StResp;
            r_a_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StResp: begin
          r_state    <= StIdle;
          r_a_ready  <= 1'b1;
          r_d_valid  <= 1'b1;
          r_d_source <= r_src;
          r_d_opcode <= w_get ? 3'd1 : 3'd0;
          r_d_error  <= !(w_get || w_put);
          r_d_data   <= w_get ? r_mem[r_addr] : '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Memory has no reset; a write only lands on a RESP edge with reset low.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == StResp) && w_put) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign a_ready    = r_a_ready;
  assign drop_count = r_drop;
  assign d_channel  = {r_d_opcode, r_d_error, r_d_data, r_d_source, r_d_valid, 1'b0};

endmodule

// File: doc/tl_mem_slave.md
Name: tl_mem_slave

Overview:
- Memory-side responder on the A/D link. Sits directly downstream of the load/store master.
- Accepts single-beat A-channel requests: Get (opcode 4) and PutFullData (opcode 0).
- Serves them from a 1024x32 word memory and returns one D-channel beat per accepted request.
- Has a runtime-programmable response delay so the master's ack-wait and secondary-FIFO retry path can be exercised.

Parameters:
- A_W, 55, A-channel width
- D_W, 40, D-channel width
- ADDR_W, 10, word address width (memory depth 2**ADDR_W)
- DATA_W, 32, data width
- BASE_LATENCY, 1, minimum cycles from request capture to response (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- a_channel  in  A_W  request: a_opcode[54:52] a_param[51:49] a_size[48:46] a_source[45:44] a_address[43:34] a_data[33:2] a_valid[1] ([0] ignored)
- a_ready  out  1  request-ready; top level routes it into a_channel[0] seen by the master
- d_channel  out  D_W  response: d_opcode[39:37] d_error[36] d_data[35:4] d_source[3:2] d_valid[1] d_ready[0] (tied 0)
- extra_wait  in  3  additional response delay cycles, sampled at request capture
- drop_count  out  8  saturating count of requests dropped while busy

Behaviour:
- Reset values: a_ready=0 during reset and 1 the cycle after; d_channel=0; drop_count=0; FSM=IDLE.
- Memory contents are not reset.
- FSM states:
  - IDLE: a_ready=1. When a_valid=1, capture opcode, size, source, address and data, plus wait = BASE_LATENCY-1+extra_wait. Go to WAIT, or go to RESP if wait=0.
  - WAIT: a_ready=0. Count down; go to RESP on reaching 0.
  - RESP: a_ready=1, d_valid=1 for exactly one cycle, then IDLE.
- Latency: request captured at edge N gives d_valid high in the cycle after edge N+BASE_LATENCY+extra_wait. Default with extra_wait=0 is 1 cycle.
- a_valid is a one-cycle pulse from the master. It is sampled only in IDLE; the slave does not wait for it to drop.
- a_valid=1 while in WAIT or RESP: request dropped, no response, drop_count increments and saturates at 255. In RESP the current response completes normally.
- Get, opcode 4, a_size=5: d_opcode=1 (AccessAckData), d_data=mem[addr], d_error=0.
- Put, opcode 0, a_size=5: mem[addr]=a_data, written on the RESP edge. d_opcode=0 (AccessAck), d_data=0, d_error=0.
- Any other opcode, or a_size!=5: no memory access, d_opcode=0, d_data=0, d_error=1.
- d_source echoes the captured a_source.
- Get to an address Put on the immediately preceding request returns the new data; there is no bypass hazard because requests are serialised.
- d_channel fields other than d_valid hold their last value after RESP; only d_valid drops.
- Reset mid-operation: the pending request is discarded with no response, and memory is unaffected unless the write edge coincided with reset deasserted.
- extra_wait changes during WAIT have no effect on the in-flight request.

Test Plan:
- Reset, Put addr 0x005 data 0xDEADBEEF size 5 source 1, extra_wait=0 -> d_valid pulse 1 cycle after capture with d_opcode=0, d_error=0, d_source=1; a_ready=1 throughout.
- Get addr 0x005 -> d_opcode=1, d_data=0xDEADBEEF, d_error=0. Then Get addr 0x3FF after Put 0x12345678 -> 0x12345678.
- extra_wait=4 on a Get -> a_ready=0 for 4 cycles, d_valid 5 cycles after capture (exceeds master wait window). Second a_valid during WAIT -> drop_count=1, only one d_valid.
- Get with a_size=0 -> d_error=1, d_data=0, memory unchanged (later Get of addr 0 returns prior value).
- Opcode 2 request -> d_error=1, d_opcode=0. 300 busy-time pulses -> drop_count stays 255.
- Assert reset while in WAIT -> no d_valid ever for that request. a_ready=0 during reset and 1 the cycle after; drop_count=0.
